ring_osc_freq_counter: RTL and testbench
========================================

RING_OSC_FREQ_COUNTER -- requirements
Module: ring_osc_freq_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of edge accumulator and count output.
REQ-002 SHALL have parameter GATE_W, default 16: width of gate-length input and gate down-counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port ena, input, 1: block enable; low aborts any measurement.
REQ-006 SHALL have port osc_in, input, 1: ring-oscillator output, asynchronous to clk.
REQ-007 SHALL have port start, input, 1: measurement request, sampled each clk edge.
REQ-008 SHALL have port gate_len, input, GATE_W: gate window length in clk cycles.
REQ-009 SHALL have port count, output, CNT_W: last completed rising-edge count.
REQ-010 SHALL have port count_valid, output, 1: count holds a completed result.
REQ-011 SHALL have port busy, output, 1: measurement in progress (state GATE or DONE).
REQ-012 SHALL have port overflow, output, 1: last completed result saturated.

Function
REQ-013 SHALL pass osc_in through a 2-flop synchronizer, then one delay flop; rise = synced & ~delayed.
REQ-014 SHALL count correctly only for osc_in high and low phases each >= 1 clk period; faster oscillators are out of range and must be prescaled upstream.
REQ-015 SHALL implement FSM states IDLE, GATE, DONE; reset state IDLE.
REQ-016 IDLE: on edge with start=1, ena=1, gate_len!=0 -> GATE; load gate_cnt=gate_len; clear acc and internal ovf flag; clear count_valid.
REQ-017 IDLE: start with gate_len=0 or ena=0 SHALL be ignored; no output changes.
REQ-018 GATE: each edge decrements gate_cnt; a rise sampled on that edge increments acc.
REQ-019 GATE: edge with gate_cnt==1 -> DONE; rises on exactly gate_len edges (edges 1..N after the start edge) are counted; a rise on the start edge itself is not counted.
REQ-020 acc SHALL saturate at 2^CNT_W-1; an increment attempted at saturation sets internal ovf flag; no wrap.
REQ-021 DONE: one cycle; next edge -> IDLE, count<=acc, overflow<=ovf flag, count_valid<=1.
REQ-022 count_valid asserts after edge N+1 following the start edge and holds until the next accepted start.
REQ-023 start while busy=1 SHALL be ignored; gate_len changes during GATE SHALL not affect the running window.
REQ-024 ena=0 in GATE or DONE -> IDLE on that edge; count, overflow unchanged; count_valid stays 0.
REQ-025 busy SHALL be a registered decode of state: 1 in GATE and DONE, 0 in IDLE.
REQ-026 Synchronizer latency (2-3 clk) SHALL shift, not shorten, the window; count error <= 1 edge.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, gate_cnt=0, acc=0, count=0, count_valid=0, busy=0, overflow=0, synchronizer and delay flops=0.
REQ-028 rst_n assertion mid-GATE SHALL discard the measurement; no partial result published.
REQ-029 Reset release SHALL take effect on the first clk edge with rst_n high; start on that edge is accepted.

Verification
REQ-030 osc_in period 4 clk (2 high/2 low), gate_len=100, start pulse -> count=25 (+/-1), overflow=0, count_valid high after edge 101, busy high for 101 cycles.
REQ-031 osc_in held 0, gate_len=10 -> count=0, count_valid=1, overflow=0.
REQ-032 CNT_W=4, osc_in toggling every clk, gate_len=64 -> count=15, overflow=1.
REQ-033 start with gate_len=0 -> busy stays 0, count_valid unchanged; second start at GATE cycle 5 of gate_len=20 -> window still ends at edge 20.
REQ-034 After valid result count=25, new start then ena=0 at GATE cycle 7 -> IDLE next edge, count=25 retained, count_valid=0.
REQ-035 rst_n pulsed low at GATE cycle 30 of gate_len=100 -> all outputs 0 asynchronously, no count_valid afterwards until a new start.

Source files
------------

// File: rtl/ring_osc_freq_counter.sv
// Ring-oscillator frequency counter: counts synchronized rising edges of osc_in
// across a programmable window of gate_len clk cycles and publishes the result.
module ring_osc_freq_counter #(
  parameter int CNT_W  = 16,
  parameter int GATE_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              osc_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  output logic [CNT_W-1:0]  count,
  output logic              count_valid,
  output logic              busy,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

  localparam logic [CNT_W-1:0] ACC_MAX = '1;

  state_t              state_q, state_d;
  logic                sync1_q, sync2_q, dly_q;
  logic                rise;
  logic [GATE_W-1:0]   gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                valid_q, valid_d;
  logic                overflow_q, overflow_d;
  logic                busy_q;

  // osc_in is asynchronous: two flops to resolve metastability, one more for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= osc_in;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign rise = sync2_q & ~dly_q;

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    count_d    = count_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (start && ena && (gate_len != '0)) begin
          state_d    = GATE;
          gate_cnt_d = gate_len;
          acc_d      = '0;
          ovf_d      = 1'b0;
          valid_d    = 1'b0;
        end
      end
      GATE: begin
        if (!ena) begin
          state_d = IDLE;
        end else begin
          gate_cnt_d = gate_cnt_q - GATE_W'(1);
          if (rise) begin
            if (acc_q == ACC_MAX) ovf_d = 1'b1;
            else                  acc_d = acc_q + CNT_W'(1);
          end
          if (gate_cnt_q == GATE_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        // An abort in the final cycle must not publish a result
        if (ena) begin
          count_d    = acc_q;
          overflow_d = ovf_q;
          valid_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign count       = count_q;
  assign count_valid = valid_q;
  assign busy        = busy_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ring_osc_freq_counter.sv
// Directed + randomized bench for ring_osc_freq_counter; a 16-bit and a 4-bit
// instance share stimulus and are checked against an edge-history reference model.
module tb_ring_osc_freq_counter;

  logic        clk = 1'b0;
  logic        rst_n, ena, osc_in, start;
  logic [15:0] gate_len;
  logic [15:0] count;
  logic        count_valid, busy, overflow;
  logic [3:0]  count4;
  logic        valid4, busy4, ovf4;

  int ntests = 0;
  int nfail  = 0;
  bit hist [0:4095];
  int ncyc = 0;
  int osc_mode = 0;
  int osc_half = 2;

  ring_osc_freq_counter #(.CNT_W(16), .GATE_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_in), .start(start),
    .gate_len(gate_len), .count(count), .count_valid(count_valid),
    .busy(busy), .overflow(overflow)
  );

  ring_osc_freq_counter #(.CNT_W(4), .GATE_W(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_in), .start(start),
    .gate_len(gate_len), .count(count4), .count_valid(valid4),
    .busy(busy4), .overflow(ovf4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clk edge: log the osc level sampled on it, then update osc for the next cycle.
  task automatic tick();
    @(posedge clk);
    if (ncyc < 4096) hist[ncyc] = osc_in;
    ncyc++;
    #1;
    case (osc_mode)
      1:       osc_in = ((ncyc / osc_half) % 2) == 1;
      2:       osc_in = 1'($urandom_range(0, 1));
      default: osc_in = 1'b0;
    endcase
  endtask

  // Rising transitions of osc as seen two cycles late, over the N edges after start edge s.
  function automatic int model_rises(input int s, input int n);
    int r = 0;
    for (int k = s + 1; k <= s + n; k++)
      if (k >= 3 && hist[k-2] && !hist[k-3]) r++;
    return r;
  endfunction

  // Full measurement of n cycles; optional stray start (with new gate_len) at GATE cycle restart_at.
  task automatic measure(input int n, input int restart_at, input string tag, output int result);
    int s, busy_n, r;
    gate_len = 16'(n);
    start = 1'b1;
    s = ncyc;
    tick();
    start = 1'b0;
    gate_len = 16'($urandom);
    busy_n = busy ? 1 : 0;
    for (int i = 1; i <= n; i++) begin
      if (i == restart_at) begin
        start = 1'b1;
        gate_len = 16'd7;
      end
      tick();
      start = 1'b0;
      if (busy) busy_n++;
      if (i == n) begin
        check({tag, "_valid_at_N"}, 32'(count_valid), 32'd0);
        check({tag, "_busy_at_N"}, 32'(busy), 32'd1);
      end
    end
    tick();
    r = model_rises(s, n);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(count_valid), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(n + 1));
    check({tag, "_count"}, 32'(count), 32'(r));
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_count4"}, 32'(count4), 32'((r > 15) ? 15 : r));
    check({tag, "_ovf4"}, 32'(ovf4), 32'(r > 15));
    check({tag, "_valid4"}, 32'(valid4), 32'd1);
    result = r;
  endtask

  initial begin
    int r, saw_valid;
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; gate_len = '0; osc_in = 1'b0;
    repeat (3) tick();
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(count_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_count4", 32'(count4), 32'd0);
    rst_n = 1'b1;
    osc_mode = 1; osc_half = 2;
    repeat (5) tick();

    // 4-cycle oscillator over 100 cycles
    measure(100, 0, "p4_g100", r);
    check("p4_g100_expect25", 32'(count), 32'd25);

    // Stuck oscillator
    osc_mode = 0;
    repeat (4) tick();
    measure(10, 0, "stuck_g10", r);
    check("stuck_count0", 32'(count), 32'd0);

    // Toggle every clk: 32 rises saturate the 4-bit instance
    osc_mode = 1; osc_half = 1;
    repeat (4) tick();
    measure(64, 0, "tog_g64", r);
    check("tog_count4_sat", 32'(count4), 32'd15);
    check("tog_ovf4_set", 32'(ovf4), 32'd1);

    // Ignored starts: zero gate length, then disabled block
    gate_len = '0; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_gate_busy", 32'(busy), 32'd0);
    check("zero_gate_valid", 32'(count_valid), 32'd1);
    ena = 1'b0; gate_len = 16'd5; start = 1'b1;
    tick();
    start = 1'b0; ena = 1'b1;
    check("ena0_start_busy", 32'(busy), 32'd0);
    check("ena0_start_valid", 32'(count_valid), 32'd1);

    // Start while busy must not restart the window
    osc_mode = 1; osc_half = 2;
    measure(20, 5, "restart_g20", r);

    // Abort via ena at GATE cycle 7 keeps the old result
    measure(100, 0, "pre_abort", r);
    check("pre_abort_25", 32'(count), 32'd25);
    gate_len = 16'd100; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    ena = 1'b0;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(count_valid), 32'd0);
    check("abort_count", 32'(count), 32'd25);
    ena = 1'b1;
    tick();
    check("abort_valid_hold", 32'(count_valid), 32'd0);

    // Asynchronous reset mid-window
    gate_len = 16'd100; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (29) tick();
    osc_mode = 0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_valid", 32'(count_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    saw_valid = 0;
    repeat (120) begin
      tick();
      if (count_valid) saw_valid = 1;
    end
    check("arst_no_valid", 32'(saw_valid), 32'd0);

    // Start on the very first edge after reset release is accepted
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    measure(5, 0, "rel_start", r);

    // Randomized oscillator and window lengths
    osc_mode = 2;
    repeat (4) tick();
    for (int t = 0; t < 6; t++) begin
      measure(int'($urandom_range(1, 60)), 0, $sformatf("rand%0d", t), r);
      repeat (int'($urandom_range(0, 3))) tick();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
